// File: rtl/corr_seq_ctrl_if.sv
// Stream bundle between the correlator sequencer and its neighbours:
// config channels, support-function and sample paths, result tap.
interface corr_seq_ctrl_if;
   logic [15:0] fft_cfg_tdata;
   logic        fft_cfg_tvalid;
   logic        fft_cfg_tready;
   logic [23:0] ifft_cfg_tdata;
   logic        ifft_cfg_tvalid;
   logic        ifft_cfg_tready;
   logic [31:0] s_sf_tdata;
   logic        s_sf_tvalid;
   logic        s_sf_tready;
   logic [31:0] m_sf_tdata;
   logic        m_sf_tvalid;
   logic        m_sf_tready;
   logic [31:0] s_rx_tdata;
   logic        s_rx_tvalid;
   logic        s_rx_tready;
   logic [31:0] m_rx_tdata;
   logic        m_rx_tvalid;
   logic        m_rx_tlast;
   logic        m_rx_tready;
   logic        res_tvalid;
   logic        res_tready;
   logic        res_tlast;

   modport master (
      output fft_cfg_tdata, fft_cfg_tvalid,
      input  fft_cfg_tready,
      output ifft_cfg_tdata, ifft_cfg_tvalid,
      input  ifft_cfg_tready,
      input  s_sf_tdata, s_sf_tvalid,
      output s_sf_tready,
      output m_sf_tdata, m_sf_tvalid,
      input  m_sf_tready,
      input  s_rx_tdata, s_rx_tvalid,
      output s_rx_tready,
      output m_rx_tdata, m_rx_tvalid, m_rx_tlast,
      input  m_rx_tready,
      input  res_tvalid, res_tready, res_tlast
   );

   modport slave (
      input  fft_cfg_tdata, fft_cfg_tvalid,
      output fft_cfg_tready,
      input  ifft_cfg_tdata, ifft_cfg_tvalid,
      output ifft_cfg_tready,
      output s_sf_tdata, s_sf_tvalid,
      input  s_sf_tready,
      input  m_sf_tdata, m_sf_tvalid,
      output m_sf_tready,
      output s_rx_tdata, s_rx_tvalid,
      input  s_rx_tready,
      input  m_rx_tdata, m_rx_tvalid, m_rx_tlast,
      output m_rx_tready,
      output res_tvalid, res_tready, res_tlast
   );
endinterface

// File: rtl/corr_seq_ctrl.sv
// Matched-filter correlator sequencer: config, SF load, framed streaming.
// Define CORR_SF_RELOAD_EN to allow support-function reload between frames.
module corr_seq_ctrl #(
   parameter int unsigned LOG2N     = 10,
   parameter logic [15:0] FFT_CFG   = 16'h0001,
   parameter logic [23:0] IFFT_CFG  = 24'h00000A,
   parameter int unsigned DRAIN_MAX = 4095
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        start,
   input  logic        stop,
   input  logic        sf_reload,
   output logic        busy,
   output logic        err,
   output logic [15:0] frame_cnt,
   corr_seq_ctrl_if.master bus
);
   localparam int WDW = $clog2(DRAIN_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, CFG_FFT, CFG_IFFT, LOAD_SF, STREAM, DRAIN
   } state_t;

   state_t state, state_nx;
   logic [LOG2N-1:0] cnt;
   logic [WDW-1:0]   wd;
   logic stop_q, sf_q;
   logic stop_eff, sf_eff;
   logic go, sf_beat, rx_beat, res_beat, timeout;

   assign go       = (state == IDLE) && start;
   assign busy     = (state != IDLE);
   assign stop_eff = stop_q | stop;
`ifdef CORR_SF_RELOAD_EN
   assign sf_eff = (sf_q | sf_reload) & ~stop_eff;
`else
   wire unused_sf_reload = sf_reload;
   assign sf_eff = 1'b0;
`endif

   always_comb begin
      state_nx             = state;
      bus.fft_cfg_tvalid   = 1'b0;
      bus.fft_cfg_tdata    = '0;
      bus.ifft_cfg_tvalid  = 1'b0;
      bus.ifft_cfg_tdata   = '0;
      bus.m_sf_tdata       = bus.s_sf_tdata;
      bus.m_sf_tvalid      = 1'b0;
      bus.s_sf_tready      = 1'b0;
      bus.m_rx_tdata       = bus.s_rx_tdata;
      bus.m_rx_tvalid      = 1'b0;
      bus.m_rx_tlast       = 1'b0;
      bus.s_rx_tready      = 1'b0;
      sf_beat              = 1'b0;
      rx_beat              = 1'b0;
      res_beat             = 1'b0;
      timeout              = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = CFG_FFT;
         end
         CFG_FFT: begin
            bus.fft_cfg_tvalid = 1'b1;
            bus.fft_cfg_tdata  = FFT_CFG;
            if (bus.fft_cfg_tready) state_nx = CFG_IFFT;
         end
         CFG_IFFT: begin
            bus.ifft_cfg_tvalid = 1'b1;
            bus.ifft_cfg_tdata  = IFFT_CFG;
            if (bus.ifft_cfg_tready) state_nx = LOAD_SF;
         end
         LOAD_SF: begin
            bus.m_sf_tvalid = bus.s_sf_tvalid;
            bus.s_sf_tready = bus.m_sf_tready;
            sf_beat = bus.s_sf_tvalid & bus.m_sf_tready;
            if (sf_beat && (&cnt)) state_nx = STREAM;
         end
         STREAM: begin
            bus.m_rx_tvalid = bus.s_rx_tvalid;
            bus.s_rx_tready = bus.m_rx_tready;
            bus.m_rx_tlast  = &cnt;
            rx_beat = bus.s_rx_tvalid & bus.m_rx_tready;
            if (rx_beat && (&cnt)) state_nx = DRAIN;
         end
         DRAIN: begin
            res_beat = bus.res_tvalid & bus.res_tready
                     & bus.res_tlast;
            if (res_beat) begin
               if (stop_eff)    state_nx = IDLE;
               else if (sf_eff) state_nx = LOAD_SF;
               else             state_nx = STREAM;
            end else if (wd == WDW'(DRAIN_MAX - 1)) begin
               timeout  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= IDLE;
         cnt       <= '0;
         wd        <= '0;
         err       <= 1'b0;
         frame_cnt <= '0;
         stop_q    <= 1'b0;
         sf_q      <= 1'b0;
      end else begin
         state <= state_nx;
         if (go)
            cnt <= '0;
         else if (sf_beat || rx_beat)
            cnt <= cnt + 1'b1;
         wd <= (state == DRAIN && state_nx == DRAIN) ?
               wd + 1'b1 : '0;
         if (go)            err <= 1'b0;
         else if (timeout)  err <= 1'b1;
         if (go)            frame_cnt <= '0;
         else if (res_beat) frame_cnt <= frame_cnt + 1'b1;
         if (go)            stop_q <= 1'b0;
         else if (stop)     stop_q <= 1'b1;
`ifdef CORR_SF_RELOAD_EN
         // stop overrides a pending reload, even one raised alongside it
         if (go || stop_eff)
            sf_q <= 1'b0;
         else if (res_beat && state_nx == LOAD_SF)
            sf_q <= 1'b0;
         else if (sf_reload)
            sf_q <= 1'b1;
`else
         sf_q <= 1'b0;
`endif
      end
   end

   wire unused_sf_q = sf_q;
endmodule

// File: tb/tb_corr_seq_ctrl.sv
// Directed bench for corr_seq_ctrl: config, framing, back-pressure,
// multi-frame stop, reload branch, drain timeout, mid-frame reset.
module tb_corr_seq_ctrl;
   localparam int N = 1024;

   logic        aclk = 1'b0;
   logic        areset, start, stop, sf_reload;
   logic        busy, err;
   logic [15:0] frame_cnt;
   int          n_chk = 0;
   int          n_pass = 0;

   corr_seq_ctrl_if bus ();

   corr_seq_ctrl dut (
      .aclk      (aclk),
      .areset    (areset),
      .start     (start),
      .stop      (stop),
      .sf_reload (sf_reload),
      .busy      (busy),
      .err       (err),
      .frame_cnt (frame_cnt),
      .bus       (bus.master)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic load_sf(output int beats, output int bad);
      int cyc;
      beats = 0; bad = 0; cyc = 0;
      while (beats < N && cyc < 4 * N) begin
         bus.s_sf_tvalid = 1'b1;
         bus.s_sf_tdata  = 32'hA000_0000 + 32'(beats);
         bus.m_sf_tready = (cyc % 3 != 2);
         #1;
         if (bus.m_sf_tvalid && bus.m_sf_tready && bus.s_sf_tready) begin
            if (bus.m_sf_tdata !== 32'hA000_0000 + 32'(beats)) bad++;
            beats++;
         end
         tick();
         cyc++;
      end
      bus.m_sf_tready = 1'b1;
      #1;
   endtask

   task automatic stream_frame(input bit rnd, input bit p_stop,
                               input bit p_rl, input int base,
                               output int beats, output int bad);
      int  cyc;
      bit  seen_last;
      beats = 0; bad = 0; cyc = 0; seen_last = 0;
      while (!seen_last && cyc < 6 * N) begin
         bus.s_rx_tvalid = 1'b1;
         bus.s_rx_tdata  = 32'(base + beats);
         bus.m_rx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stop      = p_stop && (cyc == 10);
         sf_reload = p_rl && (cyc == 10);
         #1;
         if (bus.m_rx_tvalid && bus.m_rx_tready && bus.s_rx_tready) begin
            if (bus.m_rx_tdata !== 32'(base + beats)) bad++;
            beats++;
            if (bus.m_rx_tlast) seen_last = 1;
         end
         tick();
         cyc++;
      end
      stop = 1'b0;
      sf_reload = 1'b0;
      bus.m_rx_tready = 1'b1;
      #1;
   endtask

   task automatic res_pulse();
      bus.res_tvalid = 1'b1;
      bus.res_tready = 1'b1;
      bus.res_tlast  = 1'b1;
      tick();
      bus.res_tvalid = 1'b0;
      bus.res_tready = 1'b0;
      bus.res_tlast  = 1'b0;
      #1;
   endtask

   initial begin
      int beats, bad, hold, dc, lastc;
      areset = 1'b1; start = 1'b0; stop = 1'b0; sf_reload = 1'b0;
      bus.fft_cfg_tready  = 1'b0;
      bus.ifft_cfg_tready = 1'b0;
      bus.s_sf_tdata  = 32'h1234_5678; bus.s_sf_tvalid = 1'b1;
      bus.m_sf_tready = 1'b1;
      bus.s_rx_tdata  = 32'h0; bus.s_rx_tvalid = 1'b1;
      bus.m_rx_tready = 1'b1;
      bus.res_tvalid = 1'b0; bus.res_tready = 1'b0; bus.res_tlast = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_fcnt", frame_cnt, 0);
      check("rst_fft_v", bus.fft_cfg_tvalid, 0);
      check("rst_fft_d", bus.fft_cfg_tdata, 0);
      check("rst_ifft_v", bus.ifft_cfg_tvalid, 0);
      check("rst_ifft_d", bus.ifft_cfg_tdata, 0);
      check("rst_sf_rdy", bus.s_sf_tready, 0);
      check("rst_msf_v", bus.m_sf_tvalid, 0);
      check("rst_rx_rdy", bus.s_rx_tready, 0);
      check("rst_mrx_v", bus.m_rx_tvalid, 0);
      check("rst_mrx_l", bus.m_rx_tlast, 0);
      areset = 1'b0;
      tick();

      // configuration with FFT tready withheld
      start = 1'b1; tick(); start = 1'b0; #1;
      check("cfg_fft_v", bus.fft_cfg_tvalid, 1);
      check("cfg_fft_d", bus.fft_cfg_tdata, 16'h0001);
      check("cfg_busy", busy, 1);
      check("cfg_msf_v", bus.m_sf_tvalid, 0);
      hold = 0;
      repeat (5) begin
         if (bus.fft_cfg_tvalid) hold++;
         tick();
      end
      check("cfg_hold", hold, 5);
      bus.fft_cfg_tready = 1'b1;
      tick();
      bus.fft_cfg_tready = 1'b0; #1;
      check("cfg_fft_done", bus.fft_cfg_tvalid, 0);
      check("cfg_ifft_v", bus.ifft_cfg_tvalid, 1);
      check("cfg_ifft_d", bus.ifft_cfg_tdata, 24'h00000A);
      bus.ifft_cfg_tready = 1'b1;
      tick();
      bus.ifft_cfg_tready = 1'b0; #1;
      check("cfg_ifft_done", bus.ifft_cfg_tvalid, 0);
      check("load_sf_rdy", bus.s_sf_tready, 1);

      load_sf(beats, bad);
      check("sf_beats", beats, N);
      check("sf_order", bad, 0);
      check("sf_done_rdy", bus.s_sf_tready, 0);
      check("stream_rdy", bus.s_rx_tready, 1);

      // frame 1: free-flowing
      stream_frame(0, 0, 0, 32'h1000, beats, bad);
      check("f1_beats", beats, N);
      check("f1_order", bad, 0);
      check("f1_drain_rdy", bus.s_rx_tready, 0);
      check("f1_drain_v", bus.m_rx_tvalid, 0);
      bus.res_tvalid = 1'b1; bus.res_tready = 1'b1; bus.res_tlast = 1'b0;
      tick();
      bus.res_tvalid = 1'b0; bus.res_tready = 1'b0; #1;
      check("f1_nolast_cnt", frame_cnt, 0);
      check("f1_nolast_rdy", bus.s_rx_tready, 0);
      res_pulse();
      check("f1_fcnt", frame_cnt, 1);
      check("f1_resume", bus.s_rx_tready, 1);

      // frame 2: random back-pressure, reload request mid-frame
      stream_frame(1, 0, 1, 32'h2000, beats, bad);
      check("f2_beats", beats, N);
      check("f2_order", bad, 0);
      check("f2_drain_rdy", bus.s_rx_tready, 0);
      res_pulse();
      check("f2_fcnt", frame_cnt, 2);
`ifdef CORR_SF_RELOAD_EN
      check("rl_sf_rdy", bus.s_sf_tready, 1);
      check("rl_rx_rdy", bus.s_rx_tready, 0);
      load_sf(beats, bad);
      check("rl_beats", beats, N);
      check("rl_order", bad, 0);
      check("rl_stream", bus.s_rx_tready, 1);
`else
      check("rl_sf_rdy", bus.s_sf_tready, 0);
      check("rl_rx_rdy", bus.s_rx_tready, 1);
`endif

      // frame 3: stop during the frame
      stream_frame(0, 1, 0, 32'h3000, beats, bad);
      check("f3_beats", beats, N);
      check("f3_busy_drain", busy, 1);
      res_pulse();
      check("f3_fcnt", frame_cnt, 3);
      check("f3_idle", busy, 0);
      check("f3_rx_rdy", bus.s_rx_tready, 0);

      // second run: start clears count, start while busy ignored
      bus.fft_cfg_tready = 1'b1; bus.ifft_cfg_tready = 1'b1;
      start = 1'b1; tick(); start = 1'b0; #1;
      check("r2_fcnt_clr", frame_cnt, 0);
      tick(); tick();
      bus.fft_cfg_tready = 1'b0; bus.ifft_cfg_tready = 1'b0;
      bus.m_sf_tready = 1'b0;
      start = 1'b1; tick(); start = 1'b0; #1;
      check("r2_busy_start", bus.fft_cfg_tvalid, 0);
      check("r2_busy", busy, 1);
      load_sf(beats, bad);
      check("r2_sf_beats", beats, N);
      stream_frame(0, 0, 0, 32'h4000, beats, bad);
      check("r2_beats", beats, N);
      dc = 0;
      while (busy && dc < 6000) begin
         dc++;
         tick();
      end
      check("to_cycles", dc, 4095);
      check("to_err", err, 1);
      check("to_idle", busy, 0);
      check("to_fcnt", frame_cnt, 0);
      start = 1'b1; tick(); start = 1'b0; #1;
      check("to_err_clr", err, 0);
      check("to_restart", bus.fft_cfg_tvalid, 1);

      // mid-frame reset
      bus.fft_cfg_tready = 1'b1; bus.ifft_cfg_tready = 1'b1;
      tick(); tick();
      load_sf(beats, bad);
      lastc = 0;
      for (int i = 0; i < 100; i++) begin
         bus.s_rx_tdata = 32'(i);
         #1;
         if (bus.m_rx_tlast) lastc++;
         tick();
      end
      check("ar_no_last", lastc, 0);
      areset = 1'b1; tick(); #1;
      check("ar_busy", busy, 0);
      check("ar_mrx_v", bus.m_rx_tvalid, 0);
      check("ar_mrx_l", bus.m_rx_tlast, 0);
      check("ar_rx_rdy", bus.s_rx_tready, 0);
      areset = 1'b0; tick();
      start = 1'b1; tick(); start = 1'b0; #1;
      check("ar_reconfig", bus.fft_cfg_tvalid, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
